ysyx_22050612_idu_stage: RTL and testbench

Parametrised, buffered RV32I/RV64I decode stage for the NPC core.
- Accepts fetched instructions with their PC over a valid/ready handshake.
- Decodes all six base formats (R/I/S/B/U/J) and produces a format-correct sign-extended immediate, register indices, a write-enable and an illegal flag.
- Queues decoded results in a DEPTH-entry FIFO towards EXU.
- Supports a synchronous flush for branch redirect.

---
 rtl/ysyx_22050612_idu_stage_if.sv | 32 +++
 rtl/ysyx_22050612_idu_stage.sv | 94 +++++++++
 tb/tb_ysyx_22050612_idu_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050612_idu_stage_if.sv
// ysyx_22050612_idu_stage_if: fetch-side and EXU-side handshake bundle of the decode stage
interface ysyx_22050612_idu_stage_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_inst;
  logic [XLEN-1:0]          in_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_pc;
  logic [XLEN-1:0]          out_imm;
  logic [4:0]               out_rd;
  logic [4:0]               out_rs1;
  logic [4:0]               out_rs2;
  logic [6:0]               out_opcode;
  logic [2:0]               out_fmt;
  logic                     out_rd_we;
  logic                     out_illegal;
  logic [$clog2(DEPTH):0]   occupancy;
  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2,
           out_opcode, out_fmt, out_rd_we, out_illegal, occupancy
  );
  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rd, out_rs1, out_rs2,
           out_opcode, out_fmt, out_rd_we, out_illegal, occupancy
  );
endinterface

// File: rtl/ysyx_22050612_idu_stage.sv
// ysyx_22050612_idu_stage: RV32I/RV64I decoder feeding a DEPTH-entry FIFO towards EXU
module ysyx_22050612_idu_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input logic                      clk,
  input logic                      rst_n,
  input logic                      flush,
  ysyx_22050612_idu_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5, F_X = 3'd7;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      opcode;
    logic [2:0]      fmt;
    logic            rd_we;
    logic            illegal;
  } entry_t;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  entry_t        dec;
  entry_t        head;
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   inst;
  logic [6:0]    op;
  logic          rv64, push, pop;
  assign inst = bus.in_inst;
  assign op   = inst[6:0];
  assign rv64 = XLEN == 64;
  // Opcodes not listed below (including any with inst[1:0] != 2'b11) fall through to illegal
  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.rd      = inst[11:7];
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.opcode  = op;
    dec.fmt     = (op == 7'b0110011 || (rv64 && op == 7'b0111011)) ? F_R :
                  (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111 || op == 7'b1110011 ||
                   (rv64 && op == 7'b0011011)) ? F_I :
                  op == 7'b0100011 ? F_S :
                  op == 7'b1100011 ? F_B :
                  (op == 7'b0110111 || op == 7'b0010111) ? F_U :
                  op == 7'b1101111 ? F_J : F_X;
    dec.imm     = dec.fmt == F_I ? XLEN'($signed(inst[31:20])) :
                  dec.fmt == F_S ? XLEN'($signed({inst[31:25], inst[11:7]})) :
                  dec.fmt == F_B ? XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})) :
                  dec.fmt == F_U ? XLEN'($signed({inst[31:12], 12'b0})) :
                  dec.fmt == F_J ? XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})) : '0;
    dec.illegal = dec.fmt == F_X;
    dec.rd_we   = (dec.fmt == F_R || dec.fmt == F_I || dec.fmt == F_U || dec.fmt == F_J) && |inst[11:7];
  end
  assign bus.in_ready  = !cnt_q[AW];
  assign bus.out_valid = |cnt_q;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  always_comb begin
    mem_d = mem_q;
    if (push && !flush) mem_d[wptr_q] = dec;
    wptr_d = flush ? '0 : wptr_q + AW'(push);
    rptr_d = flush ? '0 : rptr_q + AW'(pop);
    cnt_d  = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
  assign head            = mem_q[rptr_q];
  assign bus.out_pc      = head.pc;
  assign bus.out_imm     = head.imm;
  assign bus.out_rd      = head.rd;
  assign bus.out_rs1     = head.rs1;
  assign bus.out_rs2     = head.rs2;
  assign bus.out_opcode  = head.opcode;
  assign bus.out_fmt     = head.fmt;
  assign bus.out_rd_we   = head.rd_we;
  assign bus.out_illegal = head.illegal;
  assign bus.occupancy   = cnt_q;
endmodule

// File: tb/tb_ysyx_22050612_idu_stage.sv
// tb_ysyx_22050612_idu_stage: directed checks of decode, FIFO, flush and reset for XLEN=64 and XLEN=32
module tb_ysyx_22050612_idu_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ysyx_22050612_idu_stage_if #(.XLEN(64), .DEPTH(2)) a ();
  ysyx_22050612_idu_stage_if #(.XLEN(32), .DEPTH(2)) b ();
  ysyx_22050612_idu_stage #(.XLEN(64), .DEPTH(2)) u64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(a));
  ysyx_22050612_idu_stage #(.XLEN(32), .DEPTH(2)) u32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc);
    a.in_valid = v;
    a.in_inst  = inst;
    a.in_pc    = pc;
  endtask
  task automatic send(input logic [31:0] inst, input logic [63:0] pc);
    drive(1'b1, inst, pc);
    step();
    drive(1'b0, 32'h0, 64'h0);
  endtask
  task automatic pop_one;
    a.out_ready = 1'b1;
    step();
    a.out_ready = 1'b0;
  endtask
  task automatic head(input string tag, input logic [2:0] fmt, input logic [63:0] imm, input logic we, input logic ill);
    check({tag, "_valid"}, a.out_valid, 1'b1);
    check({tag, "_fmt"}, a.out_fmt, fmt);
    check({tag, "_imm"}, a.out_imm, imm);
    check({tag, "_we"}, a.out_rd_we, we);
    check({tag, "_ill"}, a.out_illegal, ill);
  endtask
  initial begin
    drive(1'b0, 32'h0, 64'h0);
    a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_inst = 32'h0; b.in_pc = 32'h0; b.out_ready = 1'b0;
    #2;
    check("rst_in_ready", a.in_ready, 1'b1);
    check("rst_out_valid", a.out_valid, 1'b0);
    check("rst_occ", a.occupancy, 2'd0);
    check("rst_imm", a.out_imm, 64'h0);
    check("rst_fmt", a.out_fmt, 3'd0);
    check("rst32_in_ready", b.in_ready, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 32'hfff00093, 64'h8000_0000);
    #1 check("no_comb_path", a.out_valid, 1'b0);
    step();
    drive(1'b0, 32'h0, 64'h0);
    head("addi", 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    check("addi_rd", a.out_rd, 5'd1);
    check("addi_rs1", a.out_rs1, 5'd0);
    check("addi_pc", a.out_pc, 64'h8000_0000);
    check("addi_occ", a.occupancy, 2'd1);
    pop_one();
    check("pop_empty", a.out_valid, 1'b0);
    send(32'h00112623, 64'h10);
    head("sw", 3'd2, 64'd12, 1'b0, 1'b0);
    check("sw_rs1", a.out_rs1, 5'd2);
    check("sw_rs2", a.out_rs2, 5'd1);
    pop_one();
    send(32'hFE000EE3, 64'h14);
    head("beq", 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    pop_one();
    send(32'h123452B7, 64'h18);
    head("lui", 3'd4, 64'h0000_0000_1234_5000, 1'b1, 1'b0);
    check("lui_rd", a.out_rd, 5'd5);
    pop_one();
    send(32'h008000EF, 64'h1c);
    head("jal", 3'd5, 64'd8, 1'b1, 1'b0);
    check("jal_rd", a.out_rd, 5'd1);
    pop_one();
    send(32'h002081B3, 64'h20);
    head("add", 3'd0, 64'd0, 1'b1, 1'b0);
    check("add_rd", a.out_rd, 5'd3);
    pop_one();
    send(32'h00000000, 64'h24);
    head("zero", 3'd7, 64'd0, 1'b0, 1'b1);
    pop_one();
    b.in_valid = 1'b1; b.in_inst = 32'h0000003B; b.in_pc = 32'h28;
    send(32'h0000003B, 64'h28);
    b.in_valid = 1'b0;
    head("addw64", 3'd0, 64'd0, 1'b0, 1'b0);
    check("addw32_valid", b.out_valid, 1'b1);
    check("addw32_ill", b.out_illegal, 1'b1);
    check("addw32_fmt", b.out_fmt, 3'd7);
    check("addw32_we", b.out_rd_we, 1'b0);
    pop_one();
    drive(1'b1, 32'h00100093, 64'h100);
    step();
    check("bp_occ1", a.occupancy, 2'd1);
    check("bp_rdy1", a.in_ready, 1'b1);
    drive(1'b1, 32'h00200113, 64'h104);
    step();
    check("bp_occ2", a.occupancy, 2'd2);
    check("bp_rdy2", a.in_ready, 1'b0);
    check("bp_headA", a.out_pc, 64'h100);
    drive(1'b1, 32'h00300193, 64'h108);
    step();
    check("bp_hold_occ", a.occupancy, 2'd2);
    check("bp_hold_rdy", a.in_ready, 1'b0);
    check("bp_hold_pc", a.out_pc, 64'h100);
    check("bp_hold_imm", a.out_imm, 64'd1);
    a.out_ready = 1'b1;
    step();
    check("bp_popA_occ", a.occupancy, 2'd1);
    check("bp_popA_rdy", a.in_ready, 1'b1);
    check("bp_headB", a.out_pc, 64'h104);
    check("bp_headB_imm", a.out_imm, 64'd2);
    step();
    check("bp_pushpop_occ", a.occupancy, 2'd1);
    check("bp_headC", a.out_pc, 64'h108);
    check("bp_headC_imm", a.out_imm, 64'd3);
    drive(1'b0, 32'h0, 64'h0);
    step();
    a.out_ready = 1'b0;
    check("bp_drained", a.out_valid, 1'b0);
    send(32'h00100093, 64'h200);
    send(32'h00200113, 64'h204);
    check("fl_occ_pre", a.occupancy, 2'd2);
    drive(1'b1, 32'h00300193, 64'h208);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    check("fl_occ", a.occupancy, 2'd0);
    check("fl_valid", a.out_valid, 1'b0);
    check("fl_rdy", a.in_ready, 1'b1);
    step();
    check("fl_absent", a.out_valid, 1'b0);
    send(32'h00100093, 64'h300);
    drive(1'b1, 32'h00200113, 64'h304);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    check("fl1_occ", a.occupancy, 2'd0);
    step();
    check("fl1_absent", a.out_valid, 1'b0);
    send(32'h00100093, 64'h400);
    check("rs_occ_pre", a.occupancy, 2'd1);
    drive(1'b1, 32'h00200113, 64'h404);
    #1 rst_n = 1'b0;
    #1;
    check("rs_occ", a.occupancy, 2'd0);
    check("rs_valid", a.out_valid, 1'b0);
    check("rs_rdy", a.in_ready, 1'b1);
    check("rs_imm", a.out_imm, 64'h0);
    check("rs_pc", a.out_pc, 64'h0);
    drive(1'b0, 32'h0, 64'h0);
    step();
    rst_n = 1'b1;
    step();
    check("rs_after", a.out_valid, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
